id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/immediate width in bits.
REQ-002 SHALL have parameter RADDR_W, default 4, register-index width in bits.
REQ-003 SHALL have parameter DRAIN_CYC, default 3, cycles from EOP capture to halt, covering the EX, MEM and WB stages.
REQ-004 Clocking is decided: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 id_valid  input  1  decode slot holds a real instruction.
REQ-008 id_rs, id_rt, id_rd  input  RADDR_W each  source and destination register indices.
REQ-009 id_rs_data, id_rt_data, id_imm  input  DATA_W each  register-file read data and immediate.
REQ-010 id_jmp, id_eop, id_ctrl_sel, id_mem_wr, id_wr_bk_sel  input  1 each  decoder control outputs.
REQ-011 id_reg_wr  input  2; id_alu_sel  input  4; id_dir_val  input  2  decoder control outputs.
REQ-012 flush  input  1  taken jump resolved in EX; kill the decode-slot instruction.
REQ-013 ex_* outputs  output  same widths as the id_* inputs  registered copies, plus ex_valid (1).
REQ-014 stall  output  1  combinational; IF/ID and PC hold this cycle.
REQ-015 halted  output  1  registered; pipeline drained after EOP.

Function
REQ-016 A load-use hazard SHALL exist when all hold: ex_valid; ex_wr_bk_sel; ex_reg_wr != 0; id_valid; ex_rd equals id_rs or id_rt.
REQ-017 On a hazard, stall SHALL be 1 and the register SHALL capture a bubble.
REQ-018 A bubble SHALL be ex_valid=0 with every ex_ control bit 0; data fields are don't-care but SHALL be zeroed.
REQ-019 Priority per edge SHALL be: rst > flush > hazard > normal capture.
REQ-020 When flush and a hazard coincide, the register SHALL capture a bubble and stall SHALL be 0.
REQ-021 Normal capture SHALL copy all id_* inputs to ex_* with 1-cycle latency, ex_valid=id_valid.
REQ-022 If id_valid=0, only control bits SHALL be forced to zero.
REQ-023 The FSM SHALL have states RUN, DRAIN and HALT.
REQ-024 RUN->DRAIN SHALL occur when an instruction with id_eop is captured normally; the EOP itself is propagated.
REQ-025 In DRAIN a counter SHALL load DRAIN_CYC-1, then decrement each cycle; at 0 the FSM SHALL go to HALT.
REQ-026 In DRAIN and HALT every capture SHALL be a bubble; stall SHALL be 0.
REQ-027 halted SHALL be 1 only in HALT; HALT is exited only by rst.
REQ-028 An EOP killed by flush SHALL NOT start DRAIN.

Reset
REQ-029 rst SHALL set state=RUN, counter=0, ex_valid=0, all ex_ outputs 0 and halted=0 on the next edge.
REQ-030 rst asserted mid-DRAIN or in HALT SHALL return to RUN with no residual bubble count.

Configuration
REQ-031 With IDEX_PERF_CNT_EN defined, the block SHALL add output stall_cnt (16 bits), counting hazard-stall cycles, saturating at 0xFFFF and cleared by rst.
REQ-032 Without IDEX_PERF_CNT_EN, the port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-033 Shared package pipe_pkg SHALL hold the ctrl_t struct (all decoder control fields), the 4-bit opcode constants (STORE, JUMP, NOP, EOP, LOAD, SHIFT) and the idex_state_t enum.
REQ-034 Hazard comparison SHALL live in sub-module hazard_detect (purely combinational); the FSM and the register stay in id_ex_stage.

Verification
REQ-035 Scenario: EX holds a load (rd=5, reg_wr=3, wr_bk_sel=1), ID holds an instruction with rs=5 -> stall=1 for one cycle, then a bubble in EX, then the ID instruction is captured.
REQ-036 Scenario: same as above but with ex_reg_wr=0 or rd=6 -> stall=0 and normal capture.
REQ-037 Scenario: flush=1 together with the hazard condition -> bubble, stall=0.
REQ-038 Scenario: EOP captured at cycle N -> EX holds EOP at N+1, bubbles follow, and halted=1 at cycle N+1+DRAIN_CYC=N+4.
REQ-039 Scenario: rst pulsed while in DRAIN -> next cycle all outputs are 0, state is RUN, and a following valid instruction is captured normally.
REQ-040 Scenario: with IDEX_PERF_CNT_EN defined, 3 hazard stalls -> stall_cnt=3; a preloaded count of 0xFFFF plus a stall stays at 0xFFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: decoder control bundle, opcode constants and ID/EX drain FSM states.
package pipe_pkg;

    localparam logic [3:0] NOP   = 4'h0;
    localparam logic [3:0] STORE = 4'h1;
    localparam logic [3:0] JUMP  = 4'h2;
    localparam logic [3:0] LOAD  = 4'h3;
    localparam logic [3:0] SHIFT = 4'h4;
    localparam logic [3:0] EOP   = 4'hF;

    typedef struct packed {
        logic       jmp;
        logic       eop;
        logic       ctrl_sel;
        logic       mem_wr;
        logic       wr_bk_sel;
        logic [1:0] reg_wr;
        logic [3:0] alu_sel;
        logic [1:0] dir_val;
    } ctrl_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } idex_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the EX-resident load and the decode slot.
module hazard_detect #(
    parameter int RADDR_W = 4
) (
    input  logic               i_ex_valid,
    input  logic               i_ex_wr_bk_sel,
    input  logic [1:0]         i_ex_reg_wr,
    input  logic [RADDR_W-1:0] i_ex_rd,
    input  logic               i_id_valid,
    input  logic [RADDR_W-1:0] i_id_rs,
    input  logic [RADDR_W-1:0] i_id_rt,
    output logic               o_hazard
);

    logic w_ex_is_load;
    logic w_match;

    // A load only matters if it will actually write a register from memory.
    assign w_ex_is_load = i_ex_valid && i_ex_wr_bk_sel && (i_ex_reg_wr != 2'b00);
    assign w_match      = (i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt);
    assign o_hazard     = w_ex_is_load && i_id_valid && w_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush, and EOP drain-to-halt FSM.
// Optional hazard-stall counter output stall_cnt when IDEX_PERF_CNT_EN is defined.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int RADDR_W   = 4,
    parameter int DRAIN_CYC = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [RADDR_W-1:0] id_rd,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_jmp,
    input  logic               id_eop,
    input  logic               id_ctrl_sel,
    input  logic               id_mem_wr,
    input  logic               id_wr_bk_sel,
    input  logic [1:0]         id_reg_wr,
    input  logic [3:0]         id_alu_sel,
    input  logic [1:0]         id_dir_val,
    input  logic               flush,
    output logic               ex_valid,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               ex_jmp,
    output logic               ex_eop,
    output logic               ex_ctrl_sel,
    output logic               ex_mem_wr,
    output logic               ex_wr_bk_sel,
    output logic [1:0]         ex_reg_wr,
    output logic [3:0]         ex_alu_sel,
    output logic [1:0]         ex_dir_val,
    output logic               stall,
`ifdef IDEX_PERF_CNT_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic               halted
);

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    idex_state_t        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_halted;
    logic               r_ex_valid;
    ctrl_t              r_ex_ctrl;
    logic [RADDR_W-1:0] r_ex_rs;
    logic [RADDR_W-1:0] r_ex_rt;
    logic [RADDR_W-1:0] r_ex_rd;
    logic [DATA_W-1:0]  r_ex_rs_data;
    logic [DATA_W-1:0]  r_ex_rt_data;
    logic [DATA_W-1:0]  r_ex_imm;

    ctrl_t w_id_ctrl;
    logic  w_hazard;
    logic  w_run;
    logic  w_bubble;
    logic  w_eop_capture;

    assign w_id_ctrl = '{jmp:       id_jmp,
                         eop:       id_eop,
                         ctrl_sel:  id_ctrl_sel,
                         mem_wr:    id_mem_wr,
                         wr_bk_sel: id_wr_bk_sel,
                         reg_wr:    id_reg_wr,
                         alu_sel:   id_alu_sel,
                         dir_val:   id_dir_val};

    hazard_detect #(
        .RADDR_W (RADDR_W)
    ) u_hazard (
        .i_ex_valid     (r_ex_valid),
        .i_ex_wr_bk_sel (r_ex_ctrl.wr_bk_sel),
        .i_ex_reg_wr    (r_ex_ctrl.reg_wr),
        .i_ex_rd        (r_ex_rd),
        .i_id_valid     (id_valid),
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .o_hazard       (w_hazard)
    );

    // Flush outranks the hazard: the stalled instruction is being killed anyway.
    assign w_run         = (r_state == RUN);
    assign stall         = w_run && w_hazard && !flush;
    assign w_bubble      = flush || !w_run || w_hazard;
    assign w_eop_capture = !w_bubble && id_valid && id_eop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_halted     <= 1'b0;
            r_ex_valid   <= 1'b0;
            r_ex_ctrl    <= '0;
            r_ex_rs      <= '0;
            r_ex_rt      <= '0;
            r_ex_rd      <= '0;
            r_ex_rs_data <= '0;
            r_ex_rt_data <= '0;
            r_ex_imm     <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_valid   <= 1'b0;
                r_ex_ctrl    <= '0;
                r_ex_rs      <= '0;
                r_ex_rt      <= '0;
                r_ex_rd      <= '0;
                r_ex_rs_data <= '0;
                r_ex_rt_data <= '0;
                r_ex_imm     <= '0;
            end else begin
                r_ex_valid   <= id_valid;
                r_ex_ctrl    <= id_valid ? w_id_ctrl : '0;
                r_ex_rs      <= id_rs;
                r_ex_rt      <= id_rt;
                r_ex_rd      <= id_rd;
                r_ex_rs_data <= id_rs_data;
                r_ex_rt_data <= id_rt_data;
                r_ex_imm     <= id_imm;
            end

            case (r_state)
                RUN: begin
                    if (w_eop_capture) begin
                        r_state <= DRAIN;
                        r_cnt   <= CNT_W'(DRAIN_CYC - 1);
                    end
                end
                DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign ex_valid     = r_ex_valid;
    assign ex_rs        = r_ex_rs;
    assign ex_rt        = r_ex_rt;
    assign ex_rd        = r_ex_rd;
    assign ex_rs_data   = r_ex_rs_data;
    assign ex_rt_data   = r_ex_rt_data;
    assign ex_imm       = r_ex_imm;
    assign ex_jmp       = r_ex_ctrl.jmp;
    assign ex_eop       = r_ex_ctrl.eop;
    assign ex_ctrl_sel  = r_ex_ctrl.ctrl_sel;
    assign ex_mem_wr    = r_ex_ctrl.mem_wr;
    assign ex_wr_bk_sel = r_ex_ctrl.wr_bk_sel;
    assign ex_reg_wr    = r_ex_ctrl.reg_wr;
    assign ex_alu_sel   = r_ex_ctrl.alu_sel;
    assign ex_dir_val   = r_ex_ctrl.dir_val;
    assign halted       = r_halted;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: stall, flush, EOP drain/halt, reset, and stall_cnt under IDEX_PERF_CNT_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_jmp, id_eop, id_ctrl_sel, id_mem_wr, id_wr_bk_sel;
    logic [1:0]  id_reg_wr;
    logic [3:0]  id_alu_sel;
    logic [1:0]  id_dir_val;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] ex_rs_data, ex_rt_data, ex_imm;
    logic        ex_jmp, ex_eop, ex_ctrl_sel, ex_mem_wr, ex_wr_bk_sel;
    logic [1:0]  ex_reg_wr;
    logic [3:0]  ex_alu_sel;
    logic [1:0]  ex_dir_val;
    logic        stall;
    logic        halted;
`ifdef IDEX_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    id_ex_stage #(
        .DATA_W    (16),
        .RADDR_W   (4),
        .DRAIN_CYC (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .id_imm       (id_imm),
        .id_jmp       (id_jmp),
        .id_eop       (id_eop),
        .id_ctrl_sel  (id_ctrl_sel),
        .id_mem_wr    (id_mem_wr),
        .id_wr_bk_sel (id_wr_bk_sel),
        .id_reg_wr    (id_reg_wr),
        .id_alu_sel   (id_alu_sel),
        .id_dir_val   (id_dir_val),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_jmp       (ex_jmp),
        .ex_eop       (ex_eop),
        .ex_ctrl_sel  (ex_ctrl_sel),
        .ex_mem_wr    (ex_mem_wr),
        .ex_wr_bk_sel (ex_wr_bk_sel),
        .ex_reg_wr    (ex_reg_wr),
        .ex_alu_sel   (ex_alu_sel),
        .ex_dir_val   (ex_dir_val),
        .stall        (stall),
`ifdef IDEX_PERF_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .halted       (halted)
    );

    // Drives one decode-slot instruction; the remaining fields derive from imm/rd so they are predictable.
    task automatic applyStimulus(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                                 input logic [3:0] rd, input logic [15:0] imm, input logic [1:0] regWr,
                                 input logic wrBk, input logic eop);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_imm       = imm;
        id_rs_data   = imm ^ 16'hFFFF;
        id_rt_data   = imm + 16'd1;
        id_reg_wr    = regWr;
        id_wr_bk_sel = wrBk;
        id_eop       = eop;
        id_jmp       = 1'b0;
        id_ctrl_sel  = 1'b1;
        id_mem_wr    = 1'b0;
        id_alu_sel   = rd;
        id_dir_val   = 2'b10;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_ex_rd", ex_rd, 0);
        checkOutput("rst_ex_imm", ex_imm, 0);
        checkOutput("rst_ex_ctrl_sel", ex_ctrl_sel, 0);

        // Normal capture of a load into EX
        rst = 1'b0;
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h5, 16'h00C3, 2'd3, 1'b1, 1'b0);
        #1;
        checkOutput("cap_stall", stall, 0);
        tick();
        checkOutput("cap_ex_valid", ex_valid, 1);
        checkOutput("cap_ex_rd", ex_rd, 5);
        checkOutput("cap_ex_rs_data", ex_rs_data, 16'hFF3C);
        checkOutput("cap_ex_rt_data", ex_rt_data, 16'h00C4);
        checkOutput("cap_ex_alu_sel", ex_alu_sel, 5);
        checkOutput("cap_ex_reg_wr", ex_reg_wr, 3);
        checkOutput("cap_ex_wr_bk_sel", ex_wr_bk_sel, 1);
        checkOutput("cap_ex_dir_val", ex_dir_val, 2);

        // Load-use hazard on rs
        applyStimulus(1'b1, 4'h5, 4'h7, 4'h8, 16'h1234, 2'd1, 1'b0, 1'b0);
        #1;
        checkOutput("haz_stall", stall, 1);
        tick();
        checkOutput("haz_bubble_valid", ex_valid, 0);
        checkOutput("haz_bubble_reg_wr", ex_reg_wr, 0);
        checkOutput("haz_bubble_imm", ex_imm, 0);
        checkOutput("haz_bubble_dir_val", ex_dir_val, 0);
        checkOutput("haz_after_stall", stall, 0);
        tick();
        checkOutput("haz_cap_valid", ex_valid, 1);
        checkOutput("haz_cap_rd", ex_rd, 8);
        checkOutput("haz_cap_imm", ex_imm, 16'h1234);

        // Load with reg_wr=0 is not a hazard
        applyStimulus(1'b1, 4'hE, 4'hE, 4'h5, 16'h0050, 2'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h5, 4'h2, 4'h3, 16'h0051, 2'd1, 1'b0, 1'b0);
        #1;
        checkOutput("nohaz_regwr_stall", stall, 0);
        tick();
        checkOutput("nohaz_regwr_imm", ex_imm, 16'h0051);

        // Load to rd=6 does not collide with rs=5
        applyStimulus(1'b1, 4'hE, 4'hE, 4'h6, 16'h0060, 2'd3, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h5, 4'h2, 4'h3, 16'h0061, 2'd1, 1'b0, 1'b0);
        #1;
        checkOutput("nohaz_rd_stall", stall, 0);
        tick();
        checkOutput("nohaz_rd_valid", ex_valid, 1);
        checkOutput("nohaz_rd_imm", ex_imm, 16'h0061);

        // Flush coinciding with a hazard
        applyStimulus(1'b1, 4'hE, 4'hE, 4'h5, 16'h0070, 2'd3, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 4'h5, 4'h2, 4'h3, 16'h0071, 2'd1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        checkOutput("flush_haz_stall", stall, 0);
        tick();
        checkOutput("flush_haz_valid", ex_valid, 0);
        checkOutput("flush_haz_reg_wr", ex_reg_wr, 0);

        // A flushed EOP must not start draining
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h9, 16'h0080, 2'd1, 1'b0, 1'b1);
        tick();
        checkOutput("flush_eop_ex_eop", ex_eop, 0);
        flush = 1'b0;
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h3, 16'h0081, 2'd1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("flush_eop_still_run", ex_valid, 1);
        checkOutput("flush_eop_halted", halted, 0);

        // id_valid=0: data copied, control cleared
        applyStimulus(1'b0, 4'h1, 4'h2, 4'h3, 16'h0099, 2'd3, 1'b1, 1'b0);
        tick();
        checkOutput("inval_valid", ex_valid, 0);
        checkOutput("inval_reg_wr", ex_reg_wr, 0);
        checkOutput("inval_ctrl_sel", ex_ctrl_sel, 0);
        checkOutput("inval_imm", ex_imm, 16'h0099);

        // EOP drain to halt
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h9, 16'h00E0, 2'd1, 1'b0, 1'b1);
        tick();
        checkOutput("eop_ex_eop", ex_eop, 1);
        checkOutput("eop_ex_valid", ex_valid, 1);
        checkOutput("eop_halted_n1", halted, 0);
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h4, 16'h00E1, 2'd1, 1'b0, 1'b0);
        tick();
        checkOutput("drain_bubble_valid", ex_valid, 0);
        checkOutput("drain_bubble_eop", ex_eop, 0);
        checkOutput("drain_halted_n2", halted, 0);
        tick();
        checkOutput("drain_halted_n3", halted, 0);
        tick();
        checkOutput("halted_n4", halted, 1);
        checkOutput("halted_ex_valid", ex_valid, 0);
        tick();
        checkOutput("halt_sticky", halted, 1);
        checkOutput("halt_stall", stall, 0);

        // Reset out of HALT, then reset in the middle of DRAIN
        rst = 1'b1;
        tick();
        checkOutput("rst_halt_halted", halted, 0);
        rst = 1'b0;
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h9, 16'h00F0, 2'd1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h4, 16'h00F1, 2'd1, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_drain_valid", ex_valid, 0);
        checkOutput("rst_drain_rd", ex_rd, 0);
        checkOutput("rst_drain_imm", ex_imm, 0);
        checkOutput("rst_drain_halted", halted, 0);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_valid", ex_valid, 1);
        checkOutput("post_rst_imm", ex_imm, 16'h00F1);
        applyStimulus(1'b1, 4'h1, 4'h2, 4'h4, 16'h00F2, 2'd1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("post_rst_no_residual", ex_valid, 1);
        checkOutput("post_rst_no_halt", halted, 0);

`ifdef IDEX_PERF_CNT_EN
        rst = 1'b1;
        tick();
        checkOutput("cnt_rst", stall_cnt, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'hE, 4'hE, 4'h5, 16'h0100, 2'd3, 1'b1, 1'b0);
            tick();
            applyStimulus(1'b1, 4'h5, 4'h2, 4'h3, 16'h0101, 2'd1, 1'b0, 1'b0);
            tick();
            tick();
        end
        checkOutput("cnt_three", stall_cnt, 3);
        force dut.r_stall_cnt = 16'hFFFF;
        applyStimulus(1'b1, 4'hE, 4'hE, 4'h5, 16'h0100, 2'd3, 1'b1, 1'b0);
        tick();
        release dut.r_stall_cnt;
        applyStimulus(1'b1, 4'h5, 4'h2, 4'h3, 16'h0101, 2'd1, 1'b0, 1'b0);
        #1;
        checkOutput("cnt_sat_stall", stall, 1);
        tick();
        checkOutput("cnt_saturated", stall_cnt, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
